// File: rtl/lab1_adder_pkg.sv
// Shared types and helpers for the lab1 sequential adder.
package lab1_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Digit-counter width for n digits; kept at least 1 bit so N=1 still has a counter.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lab1_fa_cell.sv
// One-bit full adder cell, chained DIGIT_W deep inside the digit datapath.
module lab1_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i ^ carry_i;
    assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));

endmodule

// File: rtl/lab1_seq_adder.sv
// Multi-cycle ripple adder, DIGIT_W bits per clock, valid/ready on both sides.
// Optional subtract support is enabled with the LAB1_SEQ_ADD_SUB_EN macro.
module lab1_seq_adder
    import lab1_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
`ifdef LAB1_SEQ_ADD_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_nxt, b_eff;
    logic               carry_q, cin_eff;
    logic [CW-1:0]      cnt_q;
    logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
    logic [DIGIT_W:0]   c;
    int                 idx;

    // Subtraction folds into the add path as A + ~B + 1, so the datapath never changes.
`ifdef LAB1_SEQ_ADD_SUB_EN
    assign b_eff   = sub_i ? ~b_i : b_i;
    assign cin_eff = sub_i ? 1'b1 : carry_i;
`else
    assign b_eff   = b_i;
    assign cin_eff = carry_i;
`endif

    assign idx   = int'(cnt_q) * DIGIT_W;
    assign a_dig = a_q[idx +: DIGIT_W];
    assign b_dig = b_q[idx +: DIGIT_W];
    assign c[0]  = carry_q;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
        lab1_fa_cell u_fa (
            .a_i     (a_dig[i]),
            .b_i     (b_dig[i]),
            .carry_i (c[i]),
            .sum_o   (s_dig[i]),
            .carry_o (c[i+1])
        );
    end

    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[idx +: DIGIT_W] = s_dig;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid_i)      state_nxt = RUN;
            RUN:     if (cnt_q == LAST)   state_nxt = DONE;
            DONE:    if (out_ready_i)     state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_o      <= '0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid_i) begin
                    a_q     <= a_i;
                    b_q     <= b_eff;
                    carry_q <= cin_eff;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                end
                RUN: begin
                    acc_q   <= acc_nxt;
                    carry_q <= c[DIGIT_W];
                    cnt_q   <= cnt_q + 1'b1;
                    // Result registers only move on the final digit, so partial sums stay hidden.
                    if (cnt_q == LAST) begin
                        sum_o      <= acc_nxt;
                        carry_o    <= c[DIGIT_W];
                        overflow_o <= c[DIGIT_W-1] ^ c[DIGIT_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
